// File: rtl/pipe_perf_pkg.sv
// Shared encodings for the pipeline performance monitor: FSM states,
// counter slot indices and trace-mask bit positions.
package pipe_perf_pkg;

  localparam int NUM_CNT    = 8;
  localparam int TRC_MASK_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } perf_state_e;

  // Counter slots, also the rd_sel encoding
  localparam int CNT_CYCLES  = 0;
  localparam int CNT_RETIRED = 1;
  localparam int CNT_STALL   = 2;
  localparam int CNT_FLUSH_D = 3;
  localparam int CNT_FLUSH_E = 4;
  localparam int CNT_FWD_A   = 5;
  localparam int CNT_FWD_B   = 6;
  localparam int CNT_BRANCH  = 7;

  // Bit positions inside a trace entry's mask field
  localparam int TRC_STALL  = 0;
  localparam int TRC_FLUSH  = 1;
  localparam int TRC_BRANCH = 2;

endpackage

// File: rtl/perf_trace_fifo.sv
// First-word-fall-through sync FIFO for trace entries. The head entry is
// held in its own register so data_o never comes straight off the RAM read.
// Pointers carry one extra MSB to tell full from empty. DEPTH must be a
// power of two, at least 2.
module perf_trace_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             drop_q, drop_d;
  logic             empty, full, pop_ok, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty;
  // A push into a full FIFO still lands if the head leaves in the same cycle
  assign push_ok = push_i && (!full || pop_ok);

  // Next pointers, sticky drop flag and the entry that will sit at the head
  always_comb begin
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    drop_d   = drop_q || (push_i && full && !pop_ok);
    head_d   = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      // The incoming word bypasses the RAM when it becomes the new head
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = data_i;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = 1'b0;
      head_d   = '0;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // Pointer, head and drop registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      drop_q   <= drop_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = !empty;
  assign drop_o  = drop_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Performance and hazard monitor for the pipelined RISC-V core: eight
// event counters gated by a start/stop/clear FSM, plus a timestamped
// trace of stall onsets, Execute flushes and taken branches.
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SATURATE   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_f,
  input  logic                       stall_d,
  input  logic                       flush_d,
  input  logic                       flush_e,
  input  logic [1:0]                 forward_ae,
  input  logic [1:0]                 forward_be,
  input  logic                       pcsrc_e,
  input  logic                       regwrite_w,
  input  logic [4:0]                 rd_w,
  input  logic                       cmd_start,
  input  logic                       cmd_stop,
  input  logic                       cmd_clear,
  input  logic [2:0]                 rd_sel,
  output logic [CNT_W-1:0]           rd_data,
  output logic [7:0]                 ovf,
  output logic [1:0]                 state,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [TRC_MASK_W+TS_W-1:0] trc_data,
  output logic                       trc_drop
);

  perf_state_e                   state_q;
  logic                          run;
  logic [NUM_CNT-1:0]            event_hit;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0]            ovf_q, ovf_d;
  logic [CNT_W-1:0]              rd_data_q;
  logic                          stall_d_q;
  logic [TRC_MASK_W-1:0]         trc_mask;
  logic [TS_W-1:0]               trc_ts;
  logic                          trc_push;

  assign run = (state_q == ST_RUN);

  // Control FSM: clear beats stop beats start; undefined commands are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else if (cmd_clear) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_start) state_q <= ST_RUN;
        ST_RUN:  if (cmd_stop)  state_q <= ST_HALT;
        ST_HALT: if (cmd_start) state_q <= ST_RUN;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Per-cycle qualifying event for each counter slot
  always_comb begin
    event_hit              = '0;
    event_hit[CNT_CYCLES]  = 1'b1;
    event_hit[CNT_RETIRED] = regwrite_w && (rd_w != 5'd0);
    event_hit[CNT_STALL]   = stall_f || stall_d;
    event_hit[CNT_FLUSH_D] = flush_d;
    event_hit[CNT_FLUSH_E] = flush_e;
    event_hit[CNT_FWD_A]   = (forward_ae != 2'b00);
    event_hit[CNT_FWD_B]   = (forward_be != 2'b00);
    event_hit[CNT_BRANCH]  = pcsrc_e;
  end

  // Counter next-state: saturate or wrap at all-ones and flag the overflow
  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic at_max, bump;
      assign at_max = &cnt_q[gi];
      assign bump   = run && event_hit[gi];
      assign cnt_d[gi] = cmd_clear ? '0 :
                         !bump     ? cnt_q[gi] :
                         at_max    ? ((SATURATE != 0) ? cnt_q[gi] : '0) :
                                     cnt_q[gi] + CNT_W'(1);
      assign ovf_d[gi] = !cmd_clear && (ovf_q[gi] || (bump && at_max));
    end
  endgenerate

  // Counters, overflow flags, readout register and stall-edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      stall_d_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_data_q <= cnt_q[rd_sel];
      stall_d_q <= cmd_clear ? 1'b0 : stall_d;
    end
  end

  // Trace mask: stall onset only, so a long stall yields one entry
  always_comb begin
    trc_mask             = '0;
    trc_mask[TRC_STALL]  = stall_d && !stall_d_q;
    trc_mask[TRC_FLUSH]  = flush_e;
    trc_mask[TRC_BRANCH] = pcsrc_e;
  end

  assign trc_push = run && (trc_mask != '0) && !cmd_clear;
  assign trc_ts   = TS_W'(cnt_q[CNT_CYCLES]);

  perf_trace_fifo #(
    .WIDTH (TRC_MASK_W + TS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (cmd_clear),
    .push_i  (trc_push),
    .pop_i   (trc_ready),
    .data_i  ({trc_mask, trc_ts}),
    .data_o  (trc_data),
    .valid_o (trc_valid),
    .drop_o  (trc_drop)
  );

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign state   = state_q;

endmodule
